hilo_ctrl: RTL
==============

# hilo_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the five-stage MIPS pipeline. It accepts one mult/div/mthi/mtlo operation per issue from the E stage and holds the result for the programmed latency. It drives the `busy` flag that the D-stage stall logic uses to hold any HI/LO-class instruction. `mfhi`/`mflo` read the committed HI/LO values combinationally.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: cycles from issue to HI/LO commit for mult/multu.
- `DIV_CYCLES`, default 10: cycles from issue to HI/LO commit for div/divu.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  E-stage HI/LO-class instruction valid this cycle.
- `op`  in  4  operation code (package `hilo_pkg`): NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
- `a`  in  32  rs operand (forwarded).
- `b`  in  32  rt operand (forwarded).
- `flush`  in  1  exception/interrupt taken at M this cycle; cancels an E-stage issue in the same cycle.
- `busy`  out  1  = issue of MULT..DIVU this cycle OR state != IDLE.
- `hi`  out  32  committed HI.
- `lo`  out  32  committed LO.
- `rdata`  out  32  `hi` when op=MFHI, `lo` when op=MFLO, else 0.

## Operation

- Issue condition: `start && !flush && state==IDLE`.
  - When `state != IDLE`, `start` is ignored; the stall unit guarantees this does not happen. It is a checked assertion in the bench.
- MULT/MULTU issue:
  - Capture the 64-bit product into `pend_hi`/`pend_lo`; signed for MULT, unsigned for MULTU.
  - Enter MUL and load `cnt = MULT_CYCLES-1`.
- DIV/DIVU issue:
  - Capture quotient into `pend_lo` and remainder into `pend_hi`; signed for DIV, unsigned for DIVU.
  - Signed remainder takes the sign of the dividend (truncating division).
  - Enter DIV and load `cnt = DIV_CYCLES-1`.
  - Divide by zero (`b==0`): set a `nowrite` flag. The sequence still runs the full latency, but HI/LO stay unchanged.
  - Signed 0x80000000 / -1: LO=0x80000000, HI=0.
- MTHI/MTLO issue: write `a` into HI/LO at the end of the issue cycle. No state change and no busy.
- MFHI/MFLO/NONE: no state effect.
- States:
  - IDLE: on a mul issue, go to MUL; on a div issue, go to DIV.
  - MUL/DIV: decrement `cnt` each cycle. When `cnt==0`, commit `pend_hi`/`pend_lo` to HI/LO (unless `nowrite`) and return to IDLE.
- `flush` while in MUL/DIV has no effect: the issuing instruction has already retired past M.
- Reset:
  - `hi`, `lo`, `pend_*` and `cnt` = 0.
  - `nowrite` = 0.
  - state = IDLE; `busy`=0.
  - Reset mid-operation abandons the pending result.

## Timing

- Issue cycle is T0. `busy` is high combinationally in T0 so the D-stage instruction stalls immediately.
- `busy` stays high T1..TN, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO update on the rising edge ending TN and are visible from TN+1. `busy`=0 in TN+1.
- A follow-up HI/LO instruction can issue at TN+1 at the earliest.
- MTHI/MTLO: value visible on `hi`/`lo` in T1. `busy` is never asserted.
- `rdata` is combinational from `op`, `hi` and `lo`, with zero latency.
- `start` with `flush` in the same cycle: no issue, `busy`=0 that cycle if IDLE, HI/LO unchanged.
- Parameter value 1 is legal: commit at the end of T1, `busy` high in T0..T1.

## Structure

- `hilo_pkg` holds:
  - the `op` encodings;
  - state encodings IDLE=0, MUL=1, DIV=2;
  - the `OP_IS_MULDIV` helper function (MULT..DIVU).
- The decode stage and the stall unit import the same encodings, so that a nonzero HILO type means op != NONE.
- One sub-module, `hilo_arith`: combinational signed/unsigned 32x32 multiply and divide, with outputs `{res_hi, res_lo, div_by_zero}`.
- `hilo_ctrl` holds the FSM, counter, pending registers and HI/LO.

## Test plan

- MULT a=0xFFFFFFFE (-2), b=3 -> `busy` high T0..T5, HI=0xFFFFFFFF and LO=0xFFFFFFFA at T6, `busy`=0 at T6.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> at T6: HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7, b=2 -> `busy` high T0..T10, at T11: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 -> `busy` the full 11 cycles, HI/LO unchanged.
- MTHI a=0x12345678, then MFHI next cycle -> `hi`=`rdata`=0x12345678 at T1, `busy` never high.
- MULT issued with `flush`=1 in the same cycle -> `busy`=0 every cycle, HI/LO unchanged. `flush` pulsed at T2 of a running DIV -> commit still at T11.
- `rst_n`=0 at T3 of a MULT -> from the next cycle: state IDLE, `busy`=0, HI=LO=0, and no commit occurs at T6.

Source files
------------

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - HI/LO operation and state encodings shared by decode, stall and sequencer
package hilo_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } hilo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } hilo_state_e;

  // True for the multi-cycle operations that occupy the sequencer
  function automatic logic OP_IS_MULDIV(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_arith.sv
// rtl/hilo_arith.sv - combinational 32x32 signed/unsigned multiply and divide
module hilo_arith
  import hilo_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic        w_signed;
  logic        w_is_div;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_divisor;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic        w_b_zero;

  // Division works on magnitudes so 0x80000000 / -1 falls out naturally
  // (quotient 0x80000000, remainder 0) and never hits a signed overflow.
  always_comb begin
    w_signed  = (op == OP_MULT) || (op == OP_DIV);
    w_is_div  = (op == OP_DIV) || (op == OP_DIVU);
    w_a64     = w_signed ? {{32{a[31]}}, a} : {32'b0, a};
    w_b64     = w_signed ? {{32{b[31]}}, b} : {32'b0, b};
    w_prod    = w_a64 * w_b64;
    w_a_neg   = w_signed && a[31];
    w_b_neg   = w_signed && b[31];
    w_a_mag   = w_a_neg ? (32'd0 - a) : a;
    w_b_mag   = w_b_neg ? (32'd0 - b) : b;
    w_b_zero  = (b == 32'd0);
    w_divisor = w_b_zero ? 32'd1 : w_b_mag;
    w_uq      = w_a_mag / w_divisor;
    w_ur      = w_a_mag % w_divisor;
    w_q       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
    w_r       = w_a_neg ? (32'd0 - w_ur) : w_ur;
    res_hi      = w_is_div ? w_r : w_prod[63:32];
    res_lo      = w_is_div ? w_q : w_prod[31:0];
    div_by_zero = w_is_div && w_b_zero;
  end

endmodule

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - multi-cycle mult/div sequencer owning the HI/LO register pair
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  hilo_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_nowrite;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic             w_issue;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_div_by_zero;

  hilo_arith u_arith (
    .op          (op),
    .a           (a),
    .b           (b),
    .res_hi      (w_res_hi),
    .res_lo      (w_res_lo),
    .div_by_zero (w_div_by_zero)
  );

  assign w_issue = start && !flush && (r_state == ST_IDLE);
  assign busy    = (w_issue && OP_IS_MULDIV(op)) || (r_state != ST_IDLE);
  assign hi      = r_hi;
  assign lo      = r_lo;

  // mfhi/mflo read path, zero latency
  always_comb begin
    rdata = 32'd0;
    if (op == OP_MFHI) rdata = r_hi;
    else if (op == OP_MFLO) rdata = r_lo;
  end

  // Sequencer: capture result at issue, count down the latency, then commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_nowrite <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_nowrite <= 1'b0;
                r_cnt     <= CNT_W'(MULT_CYCLES - 1);
                r_state   <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_nowrite <= w_div_by_zero;
                r_cnt     <= CNT_W'(DIV_CYCLES - 1);
                r_state   <= ST_DIV;
              end
              OP_MTHI: r_hi <= a;
              OP_MTLO: r_lo <= a;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          // flush is ignored here: the issuing instruction has already retired
          if (r_cnt == '0) begin
            if (!r_nowrite) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
